mem_arbiter: RTL and testbench

//   Shares the single synchronous memory port between the 6502 core (CPU) and a DMA/loader requester.

---
 rtl/mem_arbiter.sv | 64 ++++++
 tb/tb_mem_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous memory port between the CPU and a DMA requester,
// with DMA priority bounded by a burst limit and one-cycle read-data steering.
module mem_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 8,
  parameter int DMA_MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic              cpu_rdy,
  output logic              cpu_rd_valid,
  output logic [DATA_W-1:0] cpu_rd_data,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wr_data,
  output logic              dma_ack,
  output logic              dma_rd_valid,
  output logic [DATA_W-1:0] dma_rd_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);
  typedef enum logic [1:0] {IDLE, CPU, DMA} state_t;
  typedef enum logic [1:0] {R_NONE, R_CPU, R_DMA} owner_t;
  state_t state, state_n;
  owner_t rd_owner, rd_owner_n;
  logic [3:0] burst_cnt, burst_n;
  logic gnt_dma, gnt_cpu;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      burst_cnt <= 4'd0;
      rd_owner  <= R_NONE;
    end else begin
      state     <= state_n;
      burst_cnt <= burst_n;
      rd_owner  <= rd_owner_n;
    end
  // burst_cnt is always zero unless the previous owner was DMA, so a new run starts at 1
  always_comb begin
    gnt_dma     = !reset && dma_req && (!cpu_req || burst_cnt < 4'(DMA_MAX_BURST));
    gnt_cpu     = !reset && cpu_req && !gnt_dma;
    state_n     = gnt_dma ? DMA : gnt_cpu ? CPU : IDLE;
    burst_n     = !gnt_dma ? 4'd0 : state != DMA ? 4'd1 : burst_cnt == 4'hF ? 4'hF : burst_cnt + 4'd1;
    rd_owner_n  = gnt_dma && !dma_we ? R_DMA : gnt_cpu && !cpu_we ? R_CPU : R_NONE;
    cpu_rdy     = gnt_cpu;
    dma_ack     = gnt_dma;
    mem_en      = gnt_dma || gnt_cpu;
    mem_we      = gnt_dma ? dma_we : gnt_cpu && cpu_we;
    mem_addr    = gnt_dma ? dma_addr : gnt_cpu ? cpu_addr : '0;
    mem_wr_data = gnt_dma ? dma_wr_data : gnt_cpu ? cpu_wr_data : '0;
  end
  assign cpu_rd_valid = rd_owner == R_CPU;
  assign dma_rd_valid = rd_owner == R_DMA;
  assign cpu_rd_data  = mem_rd_data;
  assign dma_rd_data  = mem_rd_data;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter grants, burst limit, read steering and reset.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, dma_addr, mem_addr;
  logic [7:0]  cpu_wr_data, dma_wr_data, mem_wr_data, mem_rd_data, cpu_rd_data, dma_rd_data;
  logic        cpu_rdy, cpu_rd_valid, dma_ack, dma_rd_valid, mem_en, mem_we;
  logic [7:0]  mem [0:65535];
  int          errors = 0;
  int          checks = 0;
  string       pat;
  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data),
    .cpu_rdy(cpu_rdy), .cpu_rd_valid(cpu_rd_valid), .cpu_rd_data(cpu_rd_data),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wr_data(dma_wr_data),
    .dma_ack(dma_ack), .dma_rd_valid(dma_rd_valid), .dma_rd_data(dma_rd_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wr_data;
      else mem_rd_data <= mem[mem_addr];
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, ".mem_en"}, mem_en, 0);
    chk({tag, ".mem_we"}, mem_we, 0);
    chk({tag, ".cpu_rdy"}, cpu_rdy, 0);
    chk({tag, ".dma_ack"}, dma_ack, 0);
    chk({tag, ".mem_addr"}, mem_addr, 0);
    chk({tag, ".mem_wr_data"}, mem_wr_data, 0);
    chk({tag, ".cpu_rd_valid"}, cpu_rd_valid, 0);
    chk({tag, ".dma_rd_valid"}, dma_rd_valid, 0);
  endtask
  task automatic run_pattern(input string tag, input string p);
    for (int i = 0; i < p.len(); i++) begin
      @(negedge clk);
      chk($sformatf("%s.dma_ack[%0d]", tag, i), dma_ack, p[i] == "D");
      chk($sformatf("%s.cpu_rdy[%0d]", tag, i), cpu_rdy, p[i] == "C");
      chk($sformatf("%s.mem_en[%0d]", tag, i), mem_en, 1);
      chk($sformatf("%s.mem_addr[%0d]", tag, i), mem_addr, p[i] == "D" ? 16'h2000 : 16'h1000);
      next_cycle();
    end
  endtask
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFC] = 8'h34;
    mem_rd_data = 8'h00;
    reset = 1'b1;
    {cpu_req, cpu_we, dma_req, dma_we} = '0;
    cpu_addr = '0; dma_addr = '0; cpu_wr_data = '0; dma_wr_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_idle("t1_after_reset");
    next_cycle();
    cpu_req = 1'b1; cpu_addr = 16'hFFFC;
    @(negedge clk);
    chk("t2.cpu_rdy", cpu_rdy, 1);
    chk("t2.mem_en", mem_en, 1);
    chk("t2.mem_we", mem_we, 0);
    chk("t2.mem_addr", mem_addr, 16'hFFFC);
    chk("t2.dma_ack", dma_ack, 0);
    next_cycle();
    cpu_req = 1'b0;
    @(negedge clk);
    chk("t2.cpu_rd_valid", cpu_rd_valid, 1);
    chk("t2.cpu_rd_data", cpu_rd_data, 8'h34);
    chk("t2.dma_rd_valid", dma_rd_valid, 0);
    chk("t2.mem_en_off", mem_en, 0);
    next_cycle();
    cpu_req = 1'b1; cpu_addr = 16'h1000; dma_req = 1'b1; dma_addr = 16'h2000;
    pat = "DDDDCDDDDC";
    run_pattern("t3", pat);
    cpu_req = 1'b0; dma_req = 1'b0;
    next_cycle();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0200; dma_wr_data = 8'hA5;
    @(negedge clk);
    chk("t4.dma_ack", dma_ack, 1);
    chk("t4.mem_we", mem_we, 1);
    chk("t4.mem_addr", mem_addr, 16'h0200);
    chk("t4.mem_wr_data", mem_wr_data, 8'hA5);
    next_cycle();
    dma_req = 1'b0; dma_we = 1'b0; dma_wr_data = 8'h00;
    cpu_req = 1'b1; cpu_addr = 16'h0200;
    @(negedge clk);
    chk("t4.cpu_rdy", cpu_rdy, 1);
    chk("t4.no_dma_valid_after_write", dma_rd_valid, 0);
    next_cycle();
    cpu_req = 1'b0;
    @(negedge clk);
    chk("t4.cpu_rd_valid", cpu_rd_valid, 1);
    chk("t4.cpu_rd_data", cpu_rd_data, 8'hA5);
    chk("t4.dma_rd_valid", dma_rd_valid, 0);
    next_cycle();
    cpu_req = 1'b1; cpu_addr = 16'h1000; dma_req = 1'b1; dma_addr = 16'h2000;
    pat = "DD";
    run_pattern("t5a", pat);
    dma_req = 1'b0;
    pat = "C";
    run_pattern("t5b", pat);
    dma_req = 1'b1;
    pat = "DDDDC";
    run_pattern("t5c", pat);
    cpu_req = 1'b0;
    pat = "DDDDDDDDDDDDDDDD";
    run_pattern("sat_alone", pat);
    cpu_req = 1'b1;
    pat = "C";
    run_pattern("sat_cpu_first", pat);
    @(negedge clk);
    chk("t6.dma_read_granted", dma_ack, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    #1 chk_idle("t6_reset_immediate");
    @(negedge clk);
    chk_idle("t6_reset_hold1");
    next_cycle();
    @(negedge clk);
    chk_idle("t6_reset_hold2");
    next_cycle();
    reset = 1'b0;
    pat = "DDDDC";
    run_pattern("t6_after_release", pat);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
